n1_msagu: RTL and testbench
===========================

Name: n1_msagu

Overview:
- Multi-stack address generation unit; successor to the two-stack PS/RS stack-bus AGU.
- Owns STACK_CNT stack depth registers, organised as pairs sharing one stack-bus memory region.
  - Even stack of a pair grows upward from the region base.
  - Odd stack grows downward from the region top.
- Accepts push/pull/load/reset requests from the control path and runs the stack-bus cycle.
- Detects overflow (pair distance below SAFE_DIST) and underflow; rejects the offending operation.

Parameters:
SP_WIDTH, 12, stack-bus address width; also the width of each depth register.
STACK_CNT, 2, number of stacks; even, power of two, 2..8.
SAFE_DIST, 22, minimum free cells kept between the two stacks of a pair.

Ports:
clk_i  in  1  module clock
sync_rst_i  in  1  synchronous reset, active high
req_i  in  1  request valid; sampled only when rdy_o=1
req_stack_i  in  clog2(STACK_CNT)  target stack index
req_op_i  in  2  00 PUSH, 01 PULL, 10 LOAD, 11 RESET
req_load_val_i  in  SP_WIDTH  new depth for LOAD
rdy_o  out  1  FSM idle, request accepted this cycle if req_i=1
done_o  out  1  one-cycle completion pulse
err_o  out  2  valid with done_o: 00 ok, 01 overflow, 10 underflow
sbus_stb_o  out  1  stack-bus strobe
sbus_we_o  out  1  1 = write (PUSH), 0 = read (PULL)
sbus_adr_o  out  SP_WIDTH  stack-bus address
sbus_tga_o  out  clog2(STACK_CNT)  accessed stack index
sbus_ack_i  in  1  stack-bus acknowledge
depth_o  out  STACK_CNT*SP_WIDTH  current depths; stack k at bits [k*SP_WIDTH +: SP_WIDTH]

Behaviour:
- One clock, clk_i; reset is synchronous, active-high (sync_rst_i). All state updates on rising clk_i.
- Reset:
  - All depths = 0; FSM to IDLE.
  - rdy_o=1; done_o=0; err_o=0; sbus_stb_o=0; sbus_we_o=0; sbus_adr_o=0; sbus_tga_o=0.
- Region geometry:
  - RS = 2^SP_WIDTH/(STACK_CNT/2).
  - Pair p = k/2; base_p = p*RS; top_p = base_p+RS-1.
- Overflow rule:
  - Pair sum S = d_even + d_odd, computed in SP_WIDTH+1 bits.
  - An operation is illegal if it would make S + SAFE_DIST > RS.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - rdy_o=1.
  - On req_i=1, latch stack/op/load value, then:
    - PUSH, resulting S legal -> BUS, sbus_we_o=1.
      - Address even: base_p+d; odd: top_p-d.
    - PUSH, illegal -> RESP, err=01.
    - PULL, d>0 -> BUS, sbus_we_o=0.
      - Address even: base_p+d-1; odd: top_p-d+1.
    - PULL, d=0 -> RESP, err=10.
    - LOAD -> RESP.
      - If the load value makes the pair illegal: err=01, depth unchanged.
      - Else: depth := load value, err=00.
    - RESET -> RESP; depth := 0, err=00.
- BUS:
  - sbus_stb_o=1; sbus_adr_o, sbus_we_o, sbus_tga_o held stable.
  - Stays until sbus_ack_i=1.
  - On ack: depth +1 (PUSH) or -1 (PULL), stb drops, -> RESP with err=00.
- RESP:
  - done_o=1 and err_o valid for exactly this cycle; rdy_o=0 -> IDLE.
  - err_o returns to 00 outside RESP.
- Latency:
  - LOAD/RESET/rejected ops: done_o 1 cycle after acceptance.
  - PUSH/PULL: done_o in the cycle after sbus_ack_i.
  - Minimum request-to-request spacing is 2 cycles.
- Timing and ordering rules:
  - depth_o reflects registered depths; an updated depth is visible in the RESP cycle.
  - sbus_ack_i outside BUS is ignored.
  - req_i outside IDLE is ignored; the requester holds it until rdy_o=1.
  - A rejected operation never asserts sbus_stb_o.
- Reset priority:
  - sync_rst_i has priority over everything.
  - Asserted in BUS: stb drops next cycle, no done_o, depths cleared; a concurrent sbus_ack_i is discarded.
- Arithmetic boundaries:
  - Depth arithmetic never wraps: an increment is only reachable when legal, a decrement only when d>0.
  - A LOAD value >= RS is always overflow.

Test Plan:
1. SP_WIDTH=8, STACK_CNT=2, SAFE_DIST=4: PUSH stack0 -> BUS stb=1, we=1, adr=0x00, tga=0. Ack after 3 cycles -> done_o, err=00, depth0=1. PUSH stack1 -> adr=0xFF, depth1=1.
2. Same config: LOAD stack0=200, LOAD stack1=52 -> both err=00. PUSH stack0 -> done_o next cycle, err=01, no stb, depth0=200. PULL stack1 -> adr=0xCC, depth1=51.
3. PULL stack0 at depth 0 -> err=10, no stb, depth stays 0. LOAD stack1=253 with depth0=0 -> err=01, depth1 unchanged.
4. STACK_CNT=4, SP_WIDTH=8: PUSH stack2 -> adr=0x80. PUSH stack3 -> adr=0xFF. PUSH stack1 -> adr=0x7F. Pair 1 overflow does not affect pair 0 pushes.
5. sync_rst_i asserted in BUS with sbus_ack_i=1 -> next cycle stb=0, done_o=0, all depths 0, rdy_o=1.
6. RESET op on stack1 at depth 17 -> done_o after 1 cycle, err=00, depth1=0, other depths unchanged.

Source files
------------

// File: rtl/n1_msagu.sv
// Multi-stack address generation unit: stacks are paired, one pair per memory region.
// Even stacks grow up from the region base and odd stacks grow down from the region top.
module n1_msagu #(
  parameter int SP_WIDTH  = 12,
  parameter int STACK_CNT = 2,
  parameter int SAFE_DIST = 22,
  localparam int IDX_W    = $clog2(STACK_CNT)
) (
  input  logic                          clk_i,
  input  logic                          sync_rst_i,
  input  logic                          req_i,
  input  logic [IDX_W-1:0]              req_stack_i,
  input  logic [1:0]                    req_op_i,
  input  logic [SP_WIDTH-1:0]           req_load_val_i,
  output logic                          rdy_o,
  output logic                          done_o,
  output logic [1:0]                    err_o,
  output logic                          sbus_stb_o,
  output logic                          sbus_we_o,
  output logic [SP_WIDTH-1:0]           sbus_adr_o,
  output logic [IDX_W-1:0]              sbus_tga_o,
  input  logic                          sbus_ack_i,
  output logic [STACK_CNT*SP_WIDTH-1:0] depth_o
);

  // Handshake: a request is taken on any rising edge where req_i=1 and rdy_o=1;
  // the requester holds req_i until then. The stack bus completes on the first
  // rising edge with sbus_stb_o=1 and sbus_ack_i=1; ack is ignored otherwise.

  // Headroom so pair sums plus SAFE_DIST never wrap during the legality checks.
  localparam int CW = SP_WIDTH + 8;
  localparam logic [CW-1:0] RS   = (CW'(1) << SP_WIDTH) / CW'(STACK_CNT / 2);
  localparam logic [CW-1:0] SAFE = CW'(SAFE_DIST);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_PULL  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     stk_q, stk_d;
  logic                 we_q, we_d;
  logic [SP_WIDTH-1:0]  adr_q, adr_d;
  logic [1:0]           err_q, err_d;
  logic [SP_WIDTH-1:0]  depth_q [STACK_CNT];
  logic [SP_WIDTH-1:0]  depth_d [STACK_CNT];

  logic [IDX_W-1:0]     mate;
  logic [CW-1:0]        cur, oth, base, top, load_w;
  logic                 push_ok, load_ok;

  always_comb begin
    mate    = req_stack_i ^ IDX_W'(1);
    cur     = CW'(depth_q[req_stack_i]);
    oth     = CW'(depth_q[mate]);
    base    = CW'(req_stack_i >> 1) * RS;
    top     = base + RS - CW'(1);
    load_w  = CW'(req_load_val_i);
    push_ok = (cur + oth + CW'(1) + SAFE) <= RS;
    load_ok = (load_w < RS) && ((load_w + oth + SAFE) <= RS);
  end

  always_comb begin
    state_d = state_q;
    stk_d   = stk_q;
    we_d    = we_q;
    adr_d   = adr_q;
    err_d   = err_q;
    depth_d = depth_q;
    case (state_q)
      S_IDLE: begin
        err_d = ERR_OK;
        if (req_i) begin
          stk_d   = req_stack_i;
          state_d = S_RESP;
          case (req_op_i)
            OP_PUSH: begin
              if (push_ok) begin
                state_d = S_BUS;
                we_d    = 1'b1;
                adr_d   = SP_WIDTH'(req_stack_i[0] ? top - cur : base + cur);
              end else begin
                err_d = ERR_OVF;
              end
            end
            OP_PULL: begin
              if (cur != '0) begin
                state_d = S_BUS;
                we_d    = 1'b0;
                adr_d   = SP_WIDTH'(req_stack_i[0] ? top - cur + CW'(1) : base + cur - CW'(1));
              end else begin
                err_d = ERR_UNF;
              end
            end
            OP_LOAD: begin
              if (load_ok) depth_d[req_stack_i] = req_load_val_i;
              else         err_d = ERR_OVF;
            end
            default: depth_d[req_stack_i] = '0;
          endcase
        end
      end
      S_BUS: begin
        if (sbus_ack_i) begin
          // we_q distinguishes PUSH from PULL; both were checked legal at acceptance.
          depth_d[stk_q] = we_q ? depth_q[stk_q] + SP_WIDTH'(1)
                                : depth_q[stk_q] - SP_WIDTH'(1);
          err_d   = ERR_OK;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q <= S_IDLE;
      stk_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      err_q   <= ERR_OK;
      for (int k = 0; k < STACK_CNT; k++) depth_q[k] <= '0;
    end else begin
      state_q <= state_d;
      stk_q   <= stk_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      err_q   <= err_d;
      for (int k = 0; k < STACK_CNT; k++) depth_q[k] <= depth_d[k];
    end
  end

  assign rdy_o      = (state_q == S_IDLE);
  assign done_o     = (state_q == S_RESP);
  assign err_o      = (state_q == S_RESP) ? err_q : ERR_OK;
  assign sbus_stb_o = (state_q == S_BUS);
  assign sbus_we_o  = we_q;
  assign sbus_adr_o = adr_q;
  assign sbus_tga_o = stk_q;

  for (genvar k = 0; k < STACK_CNT; k++) begin : g_depth
    assign depth_o[k*SP_WIDTH +: SP_WIDTH] = depth_q[k];
  end

endmodule

// File: tb/tb_n1_msagu.sv
// Bench for n1_msagu with four 8-bit stacks (two 128-cell regions) and SAFE_DIST=4.
module tb_n1_msagu;

  localparam int SPW = 8;
  localparam int CNT = 4;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] PULL = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] RST  = 2'b11;

  logic             clk = 1'b0;
  logic             sync_rst, req, ack;
  logic [1:0]       req_stack, req_op;
  logic [SPW-1:0]   req_val;
  logic             rdy, done, stb, we;
  logic [1:0]       err, tga;
  logic [SPW-1:0]   adr;
  logic [CNT*SPW-1:0] depth;

  n1_msagu #(.SP_WIDTH(SPW), .STACK_CNT(CNT), .SAFE_DIST(4)) u_dut (
    .clk_i(clk), .sync_rst_i(sync_rst), .req_i(req), .req_stack_i(req_stack),
    .req_op_i(req_op), .req_load_val_i(req_val), .rdy_o(rdy), .done_o(done),
    .err_o(err), .sbus_stb_o(stb), .sbus_we_o(we), .sbus_adr_o(adr),
    .sbus_tga_o(tga), .sbus_ack_i(ack), .depth_o(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     op;
    logic [1:0]     stk;
    logic [SPW-1:0] val;
    int             dly;
    logic           bus;
    logic [SPW-1:0] adr;
    logic [1:0]     err;
    logic [SPW-1:0] dep;
  } vec_t;

  vec_t vecs[$];
  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [9:0] e;
    chk("rdy_idle", 32'(rdy), 1);
    req = 1'b1; req_stack = v.stk; req_op = v.op; req_val = v.val;
    exp_q.push_back({v.err, v.dep});
    tick();
    req = 1'b0;
    if (v.bus) begin
      chk("stb", 32'(stb), 1);
      chk("we", 32'(we), 32'(v.op == PUSH));
      chk("adr", 32'(adr), 32'(v.adr));
      chk("tga", 32'(tga), 32'(v.stk));
      for (int i = 0; i < v.dly; i++) begin
        tick();
        chk("stb_hold", 32'(stb), 1);
        chk("adr_hold", 32'(adr), 32'(v.adr));
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    chk("stb_resp", 32'(stb), 0);
    chk("done", 32'(done), 1);
    chk("rdy_resp", 32'(rdy), 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("err", 32'(err), 32'(e[9:8]));
      chk("depth", 32'(depth[v.stk*SPW +: SPW]), 32'(e[7:0]));
    end
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("err_clear", 32'(err), 0);
  endtask

  initial begin
    sync_rst = 1'b1; req = 1'b0; ack = 1'b0;
    req_stack = '0; req_op = '0; req_val = '0;

    //      op    stk val    dly bus adr    err    dep
    vecs.push_back('{PUSH, 0, 8'd0,   3, 1, 8'h00, 2'b00, 8'd1});
    vecs.push_back('{PUSH, 1, 8'd0,   1, 1, 8'h7F, 2'b00, 8'd1});
    vecs.push_back('{PUSH, 2, 8'd0,   0, 1, 8'h80, 2'b00, 8'd1});
    vecs.push_back('{PUSH, 3, 8'd0,   2, 1, 8'hFF, 2'b00, 8'd1});
    vecs.push_back('{PUSH, 0, 8'd0,   0, 1, 8'h01, 2'b00, 8'd2});
    vecs.push_back('{PULL, 0, 8'd0,   1, 1, 8'h01, 2'b00, 8'd1});
    vecs.push_back('{PULL, 1, 8'd0,   0, 1, 8'h7F, 2'b00, 8'd0});
    vecs.push_back('{PULL, 1, 8'd0,   0, 0, 8'h00, 2'b10, 8'd0});
    vecs.push_back('{LOAD, 0, 8'd100, 0, 0, 8'h00, 2'b00, 8'd100});
    vecs.push_back('{LOAD, 1, 8'd24,  0, 0, 8'h00, 2'b00, 8'd24});
    vecs.push_back('{PUSH, 0, 8'd0,   0, 0, 8'h00, 2'b01, 8'd100});
    vecs.push_back('{PUSH, 1, 8'd0,   0, 0, 8'h00, 2'b01, 8'd24});
    vecs.push_back('{PULL, 1, 8'd0,   1, 1, 8'h68, 2'b00, 8'd23});
    vecs.push_back('{PUSH, 0, 8'd0,   0, 1, 8'h64, 2'b00, 8'd101});
    vecs.push_back('{PUSH, 1, 8'd0,   0, 0, 8'h00, 2'b01, 8'd23});
    vecs.push_back('{LOAD, 2, 8'd128, 0, 0, 8'h00, 2'b01, 8'd1});
    vecs.push_back('{LOAD, 3, 8'd124, 0, 0, 8'h00, 2'b01, 8'd1});
    vecs.push_back('{LOAD, 3, 8'd123, 0, 0, 8'h00, 2'b00, 8'd123});
    vecs.push_back('{PUSH, 2, 8'd0,   0, 0, 8'h00, 2'b01, 8'd1});
    vecs.push_back('{PULL, 0, 8'd0,   2, 1, 8'h64, 2'b00, 8'd100});
    vecs.push_back('{PUSH, 1, 8'd0,   0, 1, 8'h68, 2'b00, 8'd24});
    vecs.push_back('{PULL, 3, 8'd0,   1, 1, 8'h85, 2'b00, 8'd122});
    vecs.push_back('{LOAD, 1, 8'd17,  0, 0, 8'h00, 2'b00, 8'd17});
    vecs.push_back('{RST,  1, 8'd0,   0, 0, 8'h00, 2'b00, 8'd0});
    vecs.push_back('{PULL, 2, 8'd0,   0, 1, 8'h80, 2'b00, 8'd0});

    repeat (3) tick();
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_adr", 32'(adr), 0);
    chk("rst_tga", 32'(tga), 0);
    chk("rst_depth", depth, 0);
    sync_rst = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
    chk("depth_all", depth, 32'h7A00_0064);

    // Reset arrives in BUS together with an ack: the ack must be discarded.
    req = 1'b1; req_stack = 2'd0; req_op = PUSH;
    tick();
    req = 1'b0;
    chk("bus_before_rst", 32'(stb), 1);
    chk("bus_adr_before_rst", 32'(adr), 32'h64);
    ack = 1'b1; sync_rst = 1'b1;
    tick();
    ack = 1'b0; sync_rst = 1'b0;
    chk("rst_bus_stb", 32'(stb), 0);
    chk("rst_bus_done", 32'(done), 0);
    chk("rst_bus_depth", depth, 0);
    chk("rst_bus_rdy", 32'(rdy), 1);
    tick();
    chk("rst_bus_no_done", 32'(done), 0);

    run_vec('{PUSH, 1, 8'd0, 0, 1, 8'h7F, 2'b00, 8'd1});

    // A stray ack while idle must not move anything.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_stb", 32'(stb), 0);
    chk("idle_ack_done", 32'(done), 0);
    chk("idle_ack_depth", depth, 32'h0000_0100);

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
